// File: rtl/snn_lif_core_if.sv
// Wishbone slave bundle used by snn_lif_core.
interface snn_lif_core_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/snn_lif_core.sv
// snn_lif_core: leaky integrate-and-fire SNN core behind a Wishbone register file.
// One timestep = N_IN accumulate cycles, one fire/leak cycle and one done cycle.
module snn_lif_core #(
    parameter int unsigned N_IN     = 8,
    parameter int unsigned N_OUT    = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic          clock,
    input  logic          resetb,
    snn_lif_core_if.slave wb,
    input  logic [3:0]    la_data_in,
    output logic [15:0]   la_data_out,
    output logic          irq
);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {StIdle, StAccum, StFire, StDone} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q;
    logic [N_IN-1:0]    in_spk_q, snap_q;
    logic signed [15:0] thresh_q;
    logic [15:0]        leak_q, steps_q;
    logic [N_OUT-1:0]   out_spk_q;
    logic               done_q, ack_q;
    logic [31:0]        dat_q, rdata;
    logic [1:0]         la_q;
    logic signed [7:0]  w_q      [N_OUT][N_IN];
    logic signed [15:0] pot_q    [N_OUT];
    logic signed [16:0] sum      [N_OUT];
    logic signed [17:0] diff     [N_OUT];
    logic signed [15:0] acc_sat  [N_OUT];
    logic signed [15:0] leak_res [N_OUT];

    logic       req, hit, wr, cfg_wr, idle, busy;
    logic [5:0] word, wrel, prel;
    logic       w_hit, p_hit, ctrl_wr, start_req, clear_req, do_start, do_clear;
    logic [7:0] spk8;
    logic       unused_ok;

    assign req   = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    assign hit   = (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign word  = wb.wbs_adr_i[7:2];
    assign wr    = req & wb.wbs_we_i & wb.wbs_sel_i[0] & hit;
    assign idle  = (state_q == StIdle);
    assign busy  = ~idle;
    assign cfg_wr = wr & idle;
    assign wrel  = word - 6'h10;
    assign prel  = word - 6'h20;
    assign w_hit = (word >= 6'h10) && (32'(wrel) < N_IN * N_OUT);
    assign p_hit = (word >= 6'h20) && (32'(prel) < N_OUT);

    assign ctrl_wr   = wr && (word == 6'h00);
    assign start_req = (ctrl_wr & wb.wbs_dat_i[0]) | (la_data_in[0] & ~la_q[0]);
    assign clear_req = (ctrl_wr & wb.wbs_dat_i[1]) | (la_data_in[1] & ~la_q[1]);
    // Clear beats start when both arrive together.
    assign do_clear  = idle & clear_req;
    assign do_start  = idle & start_req & ~clear_req;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign irq          = done_q;
    assign la_data_out  = {steps_q[5:0], done_q, busy, spk8};
    assign unused_ok    = ^{la_data_in[3:2], wb.wbs_sel_i[3:1], wb.wbs_adr_i[1:0],
                            wb.wbs_dat_i[31:16]};

    // Zero-extend output spikes onto the LA byte.
    always_comb begin
        spk8 = '0;
        spk8[N_OUT-1:0] = out_spk_q;
    end

    // Wishbone single-cycle ack and registered read data.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            if (req) dat_q <= wb.wbs_we_i ? '0 : rdata;
        end
    end

    // Read mux; in the window shared by high weights and POT, reads return POT.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (word)
                6'h01:   rdata = {30'd0, done_q, busy};
                6'h02:   rdata[N_IN-1:0] = in_spk_q;
                6'h03:   rdata = {{16{thresh_q[15]}}, thresh_q};
                6'h04:   rdata = {16'd0, leak_q};
                6'h05:   rdata[N_OUT-1:0] = out_spk_q;
                6'h06:   rdata = {16'd0, steps_q};
                default: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        for (int i = 0; i < N_IN; i++) begin
                            if (w_hit && 32'(wrel) == j * N_IN + i)
                                rdata = {{24{w_q[j][i][7]}}, w_q[j][i]};
                        end
                    end
                    for (int j = 0; j < N_OUT; j++) begin
                        if (p_hit && 32'(prel) == j) rdata = {{16{pot_q[j][15]}}, pot_q[j]};
                    end
                end
            endcase
        end
    end

    // Configuration registers and weights; frozen while a step is running.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            in_spk_q <= '0;
            thresh_q <= 16'sd64;
            leak_q   <= '0;
            la_q     <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) w_q[j][i] <= '0;
            end
        end else begin
            la_q <= la_data_in[1:0];
            if (cfg_wr && word == 6'h02) in_spk_q <= wb.wbs_dat_i[N_IN-1:0];
            if (cfg_wr && word == 6'h03) thresh_q <= wb.wbs_dat_i[15:0];
            if (cfg_wr && word == 6'h04) leak_q   <= wb.wbs_dat_i[15:0];
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (cfg_wr && w_hit && 32'(wrel) == j * N_IN + i)
                        w_q[j][i] <= wb.wbs_dat_i[7:0];
                end
            end
        end
    end

    // Next-state logic for the timestep sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (do_start) state_d = StAccum;
            StAccum: if (idx_q == IW'(N_IN - 1)) state_d = StFire;
            StFire:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, synapse index, spike snapshot, step counter and done flag.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
            idx_q   <= '0;
            snap_q  <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_start) begin
                snap_q <= in_spk_q;
                idx_q  <= '0;
                done_q <= 1'b0;
            end else if (state_q == StAccum) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == StDone) begin
                steps_q <= steps_q + 16'd1;
                done_q  <= 1'b1;
            end else if (wr && word == 6'h01 && wb.wbs_dat_i[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    // Saturating accumulate and leak-with-floor candidates for every neuron.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            sum[j]  = {pot_q[j][15], pot_q[j]} + {{9{w_q[j][idx_q][7]}}, w_q[j][idx_q]};
            acc_sat[j] = (sum[j][16] != sum[j][15]) ?
                         (sum[j][16] ? 16'sh8000 : 16'sh7fff) : sum[j][15:0];
            diff[j] = {{2{pot_q[j][15]}}, pot_q[j]} - {2'b00, leak_q};
            leak_res[j] = diff[j][17] ? 16'sd0 : diff[j][15:0];
        end
    end

    // Membrane potentials and output spikes: clear, accumulate, then fire/leak.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            out_spk_q <= '0;
            for (int j = 0; j < N_OUT; j++) pot_q[j] <= '0;
        end else if (do_clear) begin
            out_spk_q <= '0;
            for (int j = 0; j < N_OUT; j++) pot_q[j] <= '0;
        end else if (state_q == StAccum) begin
            if (snap_q[idx_q]) begin
                for (int j = 0; j < N_OUT; j++) pot_q[j] <= acc_sat[j];
            end
        end else if (state_q == StFire) begin
            for (int j = 0; j < N_OUT; j++) begin
                out_spk_q[j] <= (pot_q[j] >= thresh_q);
                pot_q[j]     <= (pot_q[j] >= thresh_q) ? 16'sd0 : leak_res[j];
            end
        end
    end
endmodule

// File: tb/tb_snn_lif_core.sv
// Self-checking bench for snn_lif_core against an integer LIF reference model.
module tb_snn_lif_core;
    localparam int N_IN  = 8;
    localparam int N_OUT = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int LAT = N_IN + 2;

    logic        clock;
    logic        resetb;
    logic [3:0]  la_data_in;
    logic [15:0] la_data_out;
    logic        irq;

    int n_cmp;
    int n_bad;

    // Reference model state
    int m_w [N_OUT][N_IN];
    int m_pot [N_OUT];
    int m_thresh, m_leak, m_steps, m_in, m_out;

    snn_lif_core_if bus ();

    snn_lif_core #(.N_IN(N_IN), .N_OUT(N_OUT), .BASE_ADR(BASE)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .wb         (bus),
        .la_data_in (la_data_in),
        .la_data_out(la_data_out),
        .irq        (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) m_w[j][i] = 0;
            m_pot[j] = 0;
        end
        m_thresh = 64; m_leak = 0; m_steps = 0; m_in = 0; m_out = 0;
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < N_OUT; j++) m_pot[j] = 0;
        m_out = 0;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N_IN; i++) begin
            if (m_in[i]) begin
                for (int j = 0; j < N_OUT; j++) begin
                    m_pot[j] = m_pot[j] + m_w[j][i];
                    if (m_pot[j] > 32767) m_pot[j] = 32767;
                    if (m_pot[j] < -32768) m_pot[j] = -32768;
                end
            end
        end
        m_out = 0;
        for (int j = 0; j < N_OUT; j++) begin
            if (m_pot[j] >= m_thresh) begin
                m_out = m_out | (1 << j);
                m_pot[j] = 0;
            end else begin
                m_pot[j] = m_pot[j] - m_leak;
                if (m_pot[j] < 0) m_pot[j] = 0;
            end
        end
        m_steps = (m_steps + 1) % 65536;
    endfunction

    function automatic logic [7:0] woff(int j, int i);
        return 8'(64 + 4 * (j * N_IN + i));
    endfunction

    function automatic logic [7:0] poff(int j);
        return 8'(128 + 4 * j);
    endfunction

    task automatic wb_access(input logic we, input logic [7:0] off, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat);
        @(negedge clock);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE | {24'd0, off};
        bus.wbs_dat_i = wdata;
        lat = 0;
        while (lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.wbs_ack_o) break;
        end
        if (!bus.wbs_ack_o) begin
            n_cmp++; n_bad++;
            $display("FAIL wb_ack_timeout off=%h got ack=0 want ack=1", off);
        end
        rdata = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] data);
        logic [31:0] d;
        int lat;
        wb_access(1'b1, off, data, d, lat);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] data);
        int lat;
        wb_access(1'b0, off, 32'd0, data, lat);
    endtask

    task automatic set_w(input int j, input int i, input int v);
        wb_write(woff(j, i), 32'(v));
        m_w[j][i] = v;
    endtask

    task automatic start_step(input bit via_la);
        if (via_la) begin
            @(negedge clock);
            la_data_in[0] = 1'b1;
            @(negedge clock);
            la_data_in[0] = 1'b0;
        end else begin
            wb_write(8'h00, 32'h1);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 4 * LAT) begin
            @(posedge clock);
            #1;
            cyc++;
            if (la_data_out[9]) break;
        end
        if (!la_data_out[9]) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout got done=0 want done=1 after %0d cycles", cyc);
        end
    endtask

    task automatic run_step(input bit via_la, output int cyc);
        start_step(via_la);
        wait_done(cyc);
        model_step();
    endtask

    task automatic test_reset();
        logic [7:0]  offs [6] = '{8'h0C, 8'h10, 8'h18, 8'h04, 8'h00, 8'h1C};
        logic [31:0] exps [6] = '{32'd64, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] d;
        int lat;
        resetb = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetb = 1'b1;
        model_reset();
        n_cmp++;
        if (la_data_out !== 16'h0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got la=%h irq=%b want la=0000 irq=0", la_data_out, irq);
        end
        for (int k = 0; k < 6; k++) begin
            wb_access(1'b0, offs[k], 32'd0, d, lat);
            n_cmp++;
            if (d !== exps[k]) begin
                n_bad++;
                $display("FAIL reset_read off=%h got %h want %h", offs[k], d, exps[k]);
            end
            n_cmp++;
            if (lat !== 1) begin
                n_bad++;
                $display("FAIL ack_latency off=%h got %0d want 1", offs[k], lat);
            end
            @(posedge clock);
            #1;
            n_cmp++;
            if (bus.wbs_ack_o !== 1'b0) begin
                n_bad++;
                $display("FAIL ack_width off=%h got ack=%b want 0", offs[k], bus.wbs_ack_o);
            end
        end
        wb_write(8'h1C, 32'hFFFF_FFFF);
        wb_read(8'h1C, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL unmapped_write got %h want 00000000", d);
        end
    endtask

    task automatic test_single_fire();
        logic [31:0] d;
        int cyc;
        set_w(0, 0, 40);
        set_w(0, 1, 30);
        set_w(0, 7, -3);
        wb_read(woff(0, 7), d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL weight_sext got %h want FFFFFFFD", d);
        end
        wb_write(8'h08, 32'h03);
        m_in = 3;
        run_step(1'b0, cyc);
        n_cmp++;
        if (cyc !== LAT) begin
            n_bad++;
            $display("FAIL step_latency got %0d want %0d", cyc, LAT);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        wb_read(8'h14, d);
        n_cmp++;
        if (d !== 32'(m_out) || d !== 32'h1) begin
            n_bad++;
            $display("FAIL out_spikes_basic got %h want %h", d, m_out);
        end
        for (int j = 0; j < N_OUT; j++) begin
            wb_read(poff(j), d);
            n_cmp++;
            if (d !== 32'(m_pot[j])) begin
                n_bad++;
                $display("FAIL pot_basic j=%0d got %h want %h", j, d, 32'(m_pot[j]));
            end
        end
        wb_read(8'h18, d);
        n_cmp++;
        if (d !== 32'd1) begin
            n_bad++;
            $display("FAIL steps_basic got %0d want 1", d);
        end
        wb_read(8'h04, d);
        n_cmp++;
        if (d !== 32'h2) begin
            n_bad++;
            $display("FAIL status_done got %h want 00000002", d);
        end
        wb_write(8'h04, 32'h2);
        n_cmp++;
        if (irq !== 1'b0 || la_data_out[9] !== 1'b0) begin
            n_bad++;
            $display("FAIL done_clear got irq=%b done=%b want 0 0", irq, la_data_out[9]);
        end
    endtask

    task automatic test_leak();
        int exp_p1 [2] = '{15, 30};
        logic [31:0] d;
        int cyc;
        set_w(1, 2, 20);
        wb_read(woff(1, 2), d);
        n_cmp++;
        if (d !== 32'd20) begin
            n_bad++;
            $display("FAIL weight_readback got %h want 00000014", d);
        end
        wb_write(8'h10, 32'd5);
        m_leak = 5;
        wb_write(8'h08, 32'h04);
        m_in = 4;
        for (int s = 0; s < 2; s++) begin
            run_step(s == 0, cyc);
            n_cmp++;
            if (cyc !== LAT) begin
                n_bad++;
                $display("FAIL leak_latency s=%0d got %0d want %0d", s, cyc, LAT);
            end
            wb_read(poff(1), d);
            n_cmp++;
            if (d !== 32'(exp_p1[s]) || d !== 32'(m_pot[1])) begin
                n_bad++;
                $display("FAIL leak_pot s=%0d got %0d want %0d", s, d, exp_p1[s]);
            end
            wb_read(8'h14, d);
            n_cmp++;
            if (d[1] !== 1'b0 || d !== 32'(m_out)) begin
                n_bad++;
                $display("FAIL leak_spikes s=%0d got %h want %h", s, d, m_out);
            end
        end
    endtask

    task automatic test_clamp();
        logic [31:0] d;
        int cyc;
        for (int i = 0; i < N_IN; i++) set_w(2, i, -128);
        wb_write(8'h08, 32'hFF);
        m_in = 255;
        run_step(1'b0, cyc);
        wb_read(8'h14, d);
        n_cmp++;
        if (d !== 32'(m_out) || d[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL clamp_spikes got %h want %h", d, m_out);
        end
        for (int j = 0; j < N_OUT; j++) begin
            wb_read(poff(j), d);
            n_cmp++;
            if (d !== 32'(m_pot[j])) begin
                n_bad++;
                $display("FAIL clamp_pot j=%0d got %h want %h", j, d, 32'(m_pot[j]));
            end
        end
        wb_write(8'h0C, 32'hFFFF_FFFB);
        m_thresh = -5;
        wb_read(8'h0C, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFB) begin
            n_bad++;
            $display("FAIL thresh_sext got %h want FFFFFFFB", d);
        end
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) set_w(j, i, 0);
        end
        run_step(1'b1, cyc);
        wb_read(8'h14, d);
        n_cmp++;
        if (d !== 32'hF || d !== 32'(m_out)) begin
            n_bad++;
            $display("FAIL neg_thresh_spikes got %h want 0000000f", d);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        int cyc;
        int fired;
        fired = 0;
        wb_write(8'h0C, 32'd32767);
        m_thresh = 32767;
        for (int i = 0; i < N_IN; i++) set_w(3, i, 127);
        for (int s = 0; s < 40; s++) begin
            if (s == 0) begin
                start_step(1'b0);
                wb_write(8'h08, 32'h0F);
                wb_write(8'h00, 32'h2);
                wb_write(8'h00, 32'h1);
                wb_read(8'h04, d);
                n_cmp++;
                if (d !== 32'h1) begin
                    n_bad++;
                    $display("FAIL status_busy got %h want 00000001", d);
                end
                wait_done(cyc);
                model_step();
                wb_read(8'h08, d);
                n_cmp++;
                if (d !== 32'hFF) begin
                    n_bad++;
                    $display("FAIL busy_write_ignored got %h want 000000ff", d);
                end
                wb_read(8'h18, d);
                n_cmp++;
                if (d !== 32'(m_steps)) begin
                    n_bad++;
                    $display("FAIL busy_start_ignored got %0d want %0d", d, m_steps);
                end
            end else begin
                run_step(s[0], cyc);
            end
            if (m_out[3]) fired++;
            wb_read(poff(3), d);
            n_cmp++;
            if (d !== 32'(m_pot[3])) begin
                n_bad++;
                $display("FAIL sat_pot s=%0d got %0d want %0d", s, d, m_pot[3]);
            end
            wb_read(8'h14, d);
            n_cmp++;
            if (d !== 32'(m_out)) begin
                n_bad++;
                $display("FAIL sat_spikes s=%0d got %h want %h", s, d, m_out);
            end
        end
        n_cmp++;
        if (fired < 1) begin
            n_bad++;
            $display("FAIL sat_fired got %0d want >=1", fired);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        int cyc;
        wb_write(8'h0C, 32'd500);
        m_thresh = 500;
        set_w(2, 0, 100);
        for (int pass = 0; pass < 2; pass++) begin
            run_step(1'b0, cyc);
            if (pass == 0) begin
                @(negedge clock);
                la_data_in[1] = 1'b1;
                @(negedge clock);
                la_data_in[1] = 1'b0;
            end else begin
                wb_write(8'h00, 32'h3);
            end
            model_clear();
            repeat (3) @(posedge clock);
            #1;
            n_cmp++;
            if (la_data_out[8] !== 1'b0 || la_data_out[7:0] !== 8'h0) begin
                n_bad++;
                $display("FAIL clear_idle pass=%0d got la=%h want busy=0 spikes=0",
                         pass, la_data_out);
            end
            for (int j = 0; j < N_OUT; j++) begin
                wb_read(poff(j), d);
                n_cmp++;
                if (d !== 32'd0) begin
                    n_bad++;
                    $display("FAIL clear_pot pass=%0d j=%0d got %h want 0", pass, j, d);
                end
            end
            wb_read(8'h18, d);
            n_cmp++;
            if (d !== 32'(m_steps)) begin
                n_bad++;
                $display("FAIL clear_steps pass=%0d got %0d want %0d", pass, d, m_steps);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int cyc;
        int v;
        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 0) begin
                for (int j = 0; j < N_OUT; j++) begin
                    for (int i = 0; i < N_IN; i++) set_w(j, i, int'($urandom_range(0, 255)) - 128);
                end
            end
            v = int'($urandom_range(0, 600)) - 100;
            wb_write(8'h0C, 32'(v));
            m_thresh = v;
            v = int'($urandom_range(0, 40));
            wb_write(8'h10, 32'(v));
            m_leak = v;
            v = int'($urandom_range(0, 255));
            wb_write(8'h08, 32'(v));
            m_in = v;
            run_step(1'($urandom_range(0, 1)), cyc);
            n_cmp++;
            if (cyc !== LAT) begin
                n_bad++;
                $display("FAIL rand_latency it=%0d got %0d want %0d", it, cyc, LAT);
            end
            wb_read(8'h14, d);
            n_cmp++;
            if (d !== 32'(m_out)) begin
                n_bad++;
                $display("FAIL rand_spikes it=%0d got %h want %h", it, d, m_out);
            end
            for (int j = 0; j < N_OUT; j++) begin
                wb_read(poff(j), d);
                n_cmp++;
                if (d !== 32'(m_pot[j])) begin
                    n_bad++;
                    $display("FAIL rand_pot it=%0d j=%0d got %h want %h", it, j, d,
                             32'(m_pot[j]));
                end
            end
        end
        wb_read(8'h18, d);
        n_cmp++;
        if (d !== 32'(m_steps)) begin
            n_bad++;
            $display("FAIL rand_steps got %0d want %0d", d, m_steps);
        end
    endtask

    task automatic test_reset_midstep();
        logic [31:0] d;
        int cyc;
        wb_write(8'h08, 32'hFF);
        start_step(1'b0);
        repeat (3) @(posedge clock);
        #2;
        resetb = 1'b0;
        #1;
        n_cmp++;
        if (la_data_out !== 16'h0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got la=%h irq=%b want 0000 0", la_data_out, irq);
        end
        @(negedge clock);
        resetb = 1'b1;
        model_reset();
        wb_read(8'h0C, d);
        n_cmp++;
        if (d !== 32'd64) begin
            n_bad++;
            $display("FAIL reset_thresh got %0d want 64", d);
        end
        for (int j = 0; j < N_OUT; j++) begin
            wb_read(poff(j), d);
            n_cmp++;
            if (d !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_pot j=%0d got %h want 0", j, d);
            end
        end
        run_step(1'b1, cyc);
        n_cmp++;
        if (cyc !== LAT) begin
            n_bad++;
            $display("FAIL la_start_latency got %0d want %0d", cyc, LAT);
        end
        n_cmp++;
        if (la_data_out[15:10] !== 6'(m_steps) || la_data_out[7:0] !== 8'(m_out)) begin
            n_bad++;
            $display("FAIL la_status got %h want steps=%0d spikes=%h", la_data_out, m_steps, m_out);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetb = 1'b0;
        la_data_in = 4'h0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        model_reset();
        test_reset();
        test_single_fire();
        test_leak();
        test_clamp();
        test_saturation();
        test_clear();
        test_random();
        test_reset_midstep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
